// File: rtl/muldiv_if.sv
// Pipeline-side bundle for the HI/LO multiply/divide unit: operands, op code,
// launch strobe, mthi/mtlo write select, and the busy/hi/lo responses.
interface muldiv_if;
    logic [31:0] D1;
    logic [31:0] D2;
    logic [2:0]  multctrl;
    logic        start;
    logic [1:0]  we;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output D1, D2, multctrl, start, we, input busy, hi, lo);
    modport slave  (input D1, D2, multctrl, start, we, output busy, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Fixed-latency multiply/divide unit owning the HI/LO registers of the E stage.
// Define MULDIV_MADD_EN to enable the madd/maddu/msub accumulate operations.
module muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [4:0]  counter;
    logic [2:0]  op;
    logic        div_zero;
    logic [31:0] rhi, rlo;
    logic [31:0] hi_q, lo_q;
    logic        busy_q;

    logic        legal;
    logic        div_ovf;
    logic [31:0] divisor;
    logic [63:0] prod_s, prod_u;
    logic [31:0] sq, sr, uq, ur;
    logic [31:0] next_hi, next_lo;
    logic        op_is_div;

    assign bus.busy = busy_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    always_comb begin
        legal = 1'b0;
        case (bus.multctrl)
            3'd1, 3'd2, 3'd3, 3'd4: legal = 1'b1;
`ifdef MULDIV_MADD_EN
            3'd5, 3'd6, 3'd7:       legal = 1'b1;
`endif
            default:                legal = 1'b0;
        endcase
    end

    // The divisor is forced to 1 for /0 and the overflow case so the divider never sees them.
    assign div_ovf = (bus.D1 == 32'h8000_0000) && (bus.D2 == 32'hFFFF_FFFF);
    assign divisor = ((bus.D2 == 32'd0) || div_ovf) ? 32'd1 : bus.D2;

    assign prod_s = $signed({{32{bus.D1[31]}}, bus.D1}) * $signed({{32{bus.D2[31]}}, bus.D2});
    assign prod_u = {32'd0, bus.D1} * {32'd0, bus.D2};
    assign sq = $signed(bus.D1) / $signed(divisor);
    assign sr = $signed(bus.D1) % $signed(divisor);
    assign uq = bus.D1 / divisor;
    assign ur = bus.D1 % divisor;

    always_comb begin
        next_hi = hi_q;
        next_lo = lo_q;
        case (bus.multctrl)
            3'd1: {next_hi, next_lo} = prod_s;
            3'd2: {next_hi, next_lo} = prod_u;
            3'd3: begin
                if (div_ovf) begin
                    next_hi = 32'd0;
                    next_lo = 32'h8000_0000;
                end else begin
                    next_hi = sr;
                    next_lo = sq;
                end
            end
            3'd4: begin
                next_hi = ur;
                next_lo = uq;
            end
`ifdef MULDIV_MADD_EN
            3'd5: {next_hi, next_lo} = {hi_q, lo_q} + prod_s;
            3'd6: {next_hi, next_lo} = {hi_q, lo_q} + prod_u;
            3'd7: {next_hi, next_lo} = {hi_q, lo_q} - prod_s;
`endif
            default: ;
        endcase
    end

    assign op_is_div = (op == 3'd3) || (op == 3'd4);

    // Result is computed at launch; RUN only counts down and commits on the last edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            counter  <= 5'd0;
            op       <= 3'd0;
            div_zero <= 1'b0;
            rhi      <= 32'd0;
            rlo      <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            busy_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && legal) begin
                        op       <= bus.multctrl;
                        rhi      <= next_hi;
                        rlo      <= next_lo;
                        div_zero <= (bus.D2 == 32'd0);
                        counter  <= ((bus.multctrl == 3'd3) || (bus.multctrl == 3'd4)) ?
                                    5'(DIV_CYCLES) : 5'(MULT_CYCLES);
                        state    <= RUN;
                        busy_q   <= 1'b1;
                    end else if (!bus.start) begin
                        if (bus.we == 2'd1)
                            hi_q <= bus.D1;
                        else if (bus.we == 2'd2)
                            lo_q <= bus.D1;
                    end
                end
                RUN: begin
                    if (counter == 5'd1) begin
                        if (!(op_is_div && div_zero)) begin
                            hi_q <= rhi;
                            lo_q <= rlo;
                        end
                        counter <= 5'd0;
                        state   <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        counter <= counter - 5'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases from the HI/LO behaviour
// plus randomized traffic compared every cycle against an arithmetic model.
module tb_muldiv_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset;
    muldiv_if bus();

    muldiv_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Model state: architectural hi/lo, cycles of busy remaining, and the result to commit.
    logic [31:0] m_hi, m_lo;
    int          m_left;
    logic [63:0] m_pend;
    bit          m_commit;

    function automatic bit legal_code(input logic [2:0] c);
`ifdef MULDIV_MADD_EN
        return c != 3'd0;
`else
        return (c >= 3'd1) && (c <= 3'd4);
`endif
    endfunction

    function automatic void ref_result(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] oh, input logic [31:0] ol,
                                       output logic [63:0] r, output bit ok);
        longint      sa, sb, q, rm;
        logic [63:0] ps, pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ps = sa * sb;
        pu = {32'd0, a} * {32'd0, b};
        ok = 1'b1;
        r  = {oh, ol};
        case (c)
            3'd1: r = ps;
            3'd2: r = pu;
            3'd3: begin
                if (b == 32'd0) ok = 1'b0;
                else begin
                    q  = sa / sb;
                    rm = sa % sb;
                    r  = {rm[31:0], q[31:0]};
                end
            end
            3'd4: begin
                if (b == 32'd0) ok = 1'b0;
                else r = {a % b, a / b};
            end
            3'd5: r = {oh, ol} + ps;
            3'd6: r = {oh, ol} + pu;
            3'd7: r = {oh, ol} - ps;
            default: ok = 1'b0;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin : model_blk
        logic [63:0] r;
        bit          ok;
        if (!reset) begin
            m_hi     <= 32'd0;
            m_lo     <= 32'd0;
            m_left   <= 0;
            m_commit <= 1'b0;
            m_pend   <= 64'd0;
        end else if (m_left > 0) begin
            if (m_left == 1 && m_commit) {m_hi, m_lo} <= m_pend;
            m_left <= m_left - 1;
        end else if (bus.start) begin
            if (legal_code(bus.multctrl)) begin
                ref_result(bus.multctrl, bus.D1, bus.D2, m_hi, m_lo, r, ok);
                m_pend   <= r;
                m_commit <= ok;
                m_left   <= (bus.multctrl == 3'd3 || bus.multctrl == 3'd4) ? DC : MC;
            end
        end else if (bus.we == 2'd1) begin
            m_hi <= bus.D1;
        end else if (bus.we == 2'd2) begin
            m_lo <= bus.D1;
        end
    end

    always @(negedge clk) begin
        check_output("cycle busy", {31'd0, bus.busy}, {31'd0, (m_left != 0)});
        check_output("cycle hi", bus.hi, m_hi);
        check_output("cycle lo", bus.lo, m_lo);
    end

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_stimulus(input logic [2:0] c, input logic st, input logic [31:0] a,
                                  input logic [31:0] b, input logic [1:0] w);
        bus.multctrl = c;
        bus.start    = st;
        bus.D1       = a;
        bus.D2       = b;
        bus.we       = w;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.we       = 2'd0;
        bus.multctrl = 3'd0;
    endtask

    task automatic run_directed(input string name, input logic [2:0] c, input logic [31:0] a,
                                input logic [31:0] b, input int n,
                                input logic [31:0] oh, input logic [31:0] ol,
                                input logic [31:0] eh, input logic [31:0] el);
        apply_stimulus(c, 1'b1, a, b, 2'd0);
        for (int i = 1; i <= n; i++) begin
            check_output($sformatf("%s busy c%0d", name, i), {31'd0, bus.busy}, 32'd1);
            check_output($sformatf("%s old hi c%0d", name, i), bus.hi, oh);
            check_output($sformatf("%s old lo c%0d", name, i), bus.lo, ol);
            idle_cycles(1);
        end
        check_output({name, " done busy"}, {31'd0, bus.busy}, 32'd0);
        check_output({name, " hi"}, bus.hi, eh);
        check_output({name, " lo"}, bus.lo, el);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.D1 = 32'd0; bus.D2 = 32'd0; bus.multctrl = 3'd0; bus.start = 1'b0; bus.we = 2'd0;
        reset = 1'b0;
        idle_cycles(3);
        check_output("reset busy", {31'd0, bus.busy}, 32'd0);
        check_output("reset hi", bus.hi, 32'd0);
        check_output("reset lo", bus.lo, 32'd0);
        reset = 1'b1;
        idle_cycles(2);

        run_directed("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, MC, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_directed("divu", 3'd4, 32'd7, 32'd2, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'd1, 32'd3);
        run_directed("div", 3'd3, 32'hFFFF_FFF9, 32'd2, DC, 32'd1, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        apply_stimulus(3'd0, 1'b0, 32'h0000_ABCD, 32'd0, 2'd1);
        check_output("mthi busy", {31'd0, bus.busy}, 32'd0);
        check_output("mthi hi", bus.hi, 32'h0000_ABCD);
        apply_stimulus(3'd0, 1'b0, 32'h11, 32'd0, 2'd1);
        apply_stimulus(3'd0, 1'b0, 32'h22, 32'd0, 2'd2);
        check_output("mtlo lo", bus.lo, 32'h22);

        run_directed("div0", 3'd3, 32'd5, 32'd0, DC, 32'h11, 32'h22, 32'h11, 32'h22);
        run_directed("divovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, DC, 32'h11, 32'h22, 32'd0, 32'h8000_0000);

        // mtlo attempt inside a multu busy window must be dropped
        apply_stimulus(3'd2, 1'b1, 32'h0001_0000, 32'h0001_0000, 2'd0);
        idle_cycles(1);
        apply_stimulus(3'd0, 1'b0, 32'h0000_DEAD, 32'd0, 2'd2);
        check_output("we busy lo held", bus.lo, 32'h8000_0000);
        idle_cycles(3);
        check_output("multu busy end", {31'd0, bus.busy}, 32'd0);
        check_output("multu hi", bus.hi, 32'd1);
        check_output("multu lo", bus.lo, 32'd0);

        apply_stimulus(3'd1, 1'b1, 32'd3, 32'd4, 2'd0);
        idle_cycles(1);
        apply_stimulus(3'd3, 1'b1, 32'd100, 32'd7, 2'd0);
        idle_cycles(2);
        check_output("restart c5 busy", {31'd0, bus.busy}, 32'd1);
        idle_cycles(1);
        check_output("restart c6 busy", {31'd0, bus.busy}, 32'd0);
        check_output("restart hi", bus.hi, 32'd0);
        check_output("restart lo", bus.lo, 32'd12);
        idle_cycles(1);
        check_output("restart c7 busy", {31'd0, bus.busy}, 32'd0);
        check_output("restart c7 lo", bus.lo, 32'd12);

        apply_stimulus(3'd1, 1'b1, 32'd5, 32'd6, 2'd0);
        idle_cycles(2);
        #2;
        reset = 1'b0;
        #1;
        check_output("async rst busy", {31'd0, bus.busy}, 32'd0);
        check_output("async rst hi", bus.hi, 32'd0);
        check_output("async rst lo", bus.lo, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle_cycles(8);
        check_output("post rst busy", {31'd0, bus.busy}, 32'd0);
        check_output("post rst lo", bus.lo, 32'd0);

        apply_stimulus(3'd0, 1'b0, 32'd0, 32'd0, 2'd1);
        apply_stimulus(3'd0, 1'b0, 32'hFFFF_FFFF, 32'd0, 2'd2);
`ifdef MULDIV_MADD_EN
        run_directed("madd", 3'd5, 32'd1, 32'd1, MC, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd0);
        run_directed("msub", 3'd7, 32'd2, 32'd3, MC, 32'd1, 32'd0, 32'd0, 32'hFFFF_FFFA);
`else
        apply_stimulus(3'd5, 1'b1, 32'd1, 32'd1, 2'd0);
        check_output("madd off busy", {31'd0, bus.busy}, 32'd0);
        idle_cycles(MC);
        check_output("madd off hi", bus.hi, 32'd0);
        check_output("madd off lo", bus.lo, 32'hFFFF_FFFF);
`endif

        for (int i = 0; i < 1500; i++) begin
            logic [31:0] a, b;
            a = pick_operand();
            b = pick_operand();
            if ($urandom_range(0, 30) == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            apply_stimulus(3'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0), a, b,
                           2'($urandom_range(0, 3)));
        end
        idle_cycles(DC + 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
